sbox_layer_iter: RTL and testbench

Parametrised, iterative 4-bit S-box substitution layer for the block-cipher datapath. It takes a STATE_W-bit state and substitutes every nibble through the 4-bit S-box, LANES nibbles per clock. It uses a valid/ready handshake on both input and output. An optional inverse mode supports decryption. It sits between key-addition and the permutation layer in the round engine.

---
 rtl/sbox_pkg.sv | 25 ++
 rtl/sbox4_lut.sv | 19 +
 rtl/sbox_layer_iter.sv | 125 ++++++++++++
 tb/tb_sbox_layer_iter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_pkg.sv
// Shared S-box tables, lookup helper and FSM encoding for the iterative substitution layer.
package sbox_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Entry x sits at index x; each concatenation lists x=F down to x=0.
    localparam logic [15:0][3:0] SBOX_FWD = {
        4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
        4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
    };

    localparam logic [15:0][3:0] SBOX_INV = {
        4'hA, 4'h9, 4'h7, 4'h0, 4'h3, 4'h6, 4'h4, 4'hB,
        4'hD, 4'h2, 4'h1, 4'hC, 4'h8, 4'hF, 4'hE, 4'h5
    };

    function automatic logic [3:0] sbox4(input logic [3:0] x, input logic inv);
        return inv ? SBOX_INV[x] : SBOX_FWD[x];
    endfunction

endpackage

// File: rtl/sbox4_lut.sv
// Single 4-bit S-box lane. With SBOX_INVERSE_EN defined, inv selects the inverse table;
// otherwise only the forward table exists and inv is ignored.
module sbox4_lut
    import sbox_pkg::*;
(
    input  logic [3:0] nib_in,
    input  logic       inv,
    output logic [3:0] nib_out_c
);

`ifdef SBOX_INVERSE_EN
    assign nib_out_c = sbox4(nib_in, inv);
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign nib_out_c  = SBOX_FWD[nib_in];
`endif

endmodule

// File: rtl/sbox_layer_iter.sv
// Iterative S-box layer: substitutes LANES nibbles per clock with valid/ready on both sides.
// Optional inverse (decrypt) tables are enabled by defining SBOX_INVERSE_EN.
module sbox_layer_iter
    import sbox_pkg::*;
#(
    parameter int unsigned STATE_W = 64,
    parameter int unsigned LANES   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int unsigned NIB   = STATE_W / 4;
    localparam int unsigned BEATS = NIB / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned POS_W = $clog2(STATE_W);

    fsm_t                    state_q, state_d;
    logic [STATE_W-1:0]      work_q, work_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    inv_q, inv_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    last_beat;
    logic [POS_W-1:0]        base;
    logic [LANES-1:0][3:0]   lane_in;
    logic [LANES-1:0][3:0]   lane_out;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
    assign base      = POS_W'(32'(cnt_q) * LANES * 4);

    // Gather the nibbles addressed by the current beat.
    always_comb begin
        lane_in = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_in[l] = work_q[base + POS_W'(l * 4) +: 4];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox4_lut u_lut (
            .nib_in    (lane_in[l]),
            .inv       (inv_q),
            .nib_out_c (lane_out[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last_beat) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates and registered handshake outputs follow the next state.
    always_comb begin
        work_d      = work_q;
        cnt_d       = cnt_q;
        inv_d       = inv_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = in_state;
                    inv_d  = in_inv;
                    cnt_d  = '0;
                end
            end
            BUSY: begin
                for (int l = 0; l < int'(LANES); l++) begin
                    work_d[base + POS_W'(l * 4) +: 4] = lane_out[l];
                end
                cnt_d = last_beat ? '0 : cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q      <= '0;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // in_ready must read low for the whole time reset is asserted.
    assign in_ready  = in_ready_q & rst_n;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_sbox_layer_iter.sv
// Self-checking bench for sbox_layer_iter (LANES=4 main instance, LANES=1/16 sweep instances).
module tb_sbox_layer_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, busy;
    logic [63:0] in_state = '0, out_state;

    logic        s_in_valid = 1'b0, s_in_inv = 1'b0, s_out_ready = 1'b1;
    logic [63:0] s_in_state = '0;
    logic        a_in_ready, a_out_valid, a_busy;
    logic [63:0] a_out_state;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [63:0] b_out_state;

    sbox_layer_iter #(.STATE_W(64), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .busy(busy)
    );

    sbox_layer_iter #(.STATE_W(64), .LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(a_in_ready),
        .in_state(s_in_state), .in_inv(s_in_inv), .out_valid(a_out_valid),
        .out_ready(s_out_ready), .out_state(a_out_state), .busy(a_busy)
    );

    sbox_layer_iter #(.STATE_W(64), .LANES(16)) dut_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(b_in_ready),
        .in_state(s_in_state), .in_inv(s_in_inv), .out_valid(b_out_valid),
        .out_ready(s_out_ready), .out_state(b_out_state), .busy(b_busy)
    );

`ifdef SBOX_INVERSE_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] inv_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                               4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    int n_vec = 0;
    int n_err = 0;

    // Whole-state reference: every nibble looked up in the selected table.
    function automatic logic [63:0] ref_sub(input logic [63:0] s, input logic inv);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (inv && INV_EN) r[i*4 +: 4] = inv_t[s[i*4 +: 4]];
            else               r[i*4 +: 4] = fwd_t[s[i*4 +: 4]];
        end
        return r;
    endfunction

    // Drives one transaction on the main instance with out_ready held high.
    task automatic do_txn(input logic [63:0] st, input logic inv, output logic [63:0] res,
                          output int lat, output int low_cnt, output bit tmo);
        @(negedge clk);
        in_state = st;
        in_inv   = inv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_inv   = 1'b0;
        lat = 0;
        low_cnt = in_ready ? 0 : 1;
        tmo = 1'b0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (!in_ready) low_cnt++;
        end
        res = out_state;
        if (lat >= 200) tmo = 1'b1;
        for (int g = 0; g < 200 && !in_ready; g++) begin
            @(posedge clk); #1;
            if (!in_ready) low_cnt++;
        end
        if (!in_ready) tmo = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (out_state !== 64'h0) begin n_err++; $display("FAIL reset_out_state: got %h expected 0", out_state); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_forward_vector();
        logic [63:0] res; int lat, low; bit tmo;
        do_txn(64'h0123456789ABCDEF, 1'b0, res, lat, low, tmo);
        n_vec++; if (tmo) begin n_err++; $display("FAIL fwd_timeout: got timeout expected completion"); end
        n_vec++; if (res !== 64'hC56B90AD3EF84712) begin n_err++; $display("FAIL fwd_vector: got %h expected c56b90ad3ef84712", res); end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL fwd_latency: got %0d expected 4", lat); end
        n_vec++; if (low !== 5) begin n_err++; $display("FAIL fwd_ready_low: got %0d expected 5", low); end
    endtask

    task automatic test_inverse();
        logic [63:0] res, exp; int lat, low; bit tmo;
        exp = ref_sub(64'hC56B90AD3EF84712, 1'b1);
        do_txn(64'hC56B90AD3EF84712, 1'b1, res, lat, low, tmo);
        n_vec++; if (tmo || res !== exp) begin n_err++; $display("FAIL inv_vector: got %h expected %h", res, exp); end
`ifdef SBOX_INVERSE_EN
        n_vec++; if (res !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL inv_roundtrip: got %h expected 0123456789abcdef", res); end
`endif
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL inv_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_backpressure();
        int  w;
        bit  bad_busy;
        out_ready = 1'b0;
        @(negedge clk);
        in_state = 64'h0; in_inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
        n_vec++; if (w !== 4) begin n_err++; $display("FAIL bp_latency: got %0d expected 4", w); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            in_state = 64'hDEADBEEF00C0FFEE;
            @(posedge clk); #1;
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
            n_vec++; if (out_state !== 64'hCCCCCCCCCCCCCCCC) begin n_err++; $display("FAIL bp_hold_state[%0d]: got %h expected cccccccccccccccc", i, out_state); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_consume: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
        bad_busy = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (busy || out_valid) bad_busy = 1'b1; end
        n_vec++; if (bad_busy) begin n_err++; $display("FAIL bp_ignored_pulse: got activity expected idle"); end
    endtask

    task automatic test_reset_midop();
        logic [63:0] res; int lat, low; bit tmo, spurious;
        @(negedge clk);
        in_state = 64'h0123456789ABCDEF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midop_abort: got valid=%b busy=%b expected 0/0", out_valid, busy); end
        n_vec++; if (out_state !== 64'h0 || in_ready !== 1'b0) begin n_err++; $display("FAIL midop_clear: got state=%h ready=%b expected 0/0", out_state, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (out_valid || busy) spurious = 1'b1; end
        n_vec++; if (spurious) begin n_err++; $display("FAIL midop_no_output: got activity expected idle"); end
        do_txn(64'hFFFFFFFFFFFFFFFF, 1'b0, res, lat, low, tmo);
        n_vec++; if (tmo || res !== 64'h2222222222222222) begin n_err++; $display("FAIL midop_next: got %h expected 2222222222222222", res); end
    endtask

    task automatic test_random();
        logic [63:0] st, res, exp; logic inv; int lat, low; bit tmo;
        for (int i = 0; i < 24; i++) begin
            st  = {$urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            exp = ref_sub(st, inv);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_txn(st, inv, res, lat, low, tmo);
            n_vec++; if (tmo || res !== exp) begin n_err++; $display("FAIL rand_vec[%0d]: got %h expected %h", i, res, exp); end
            n_vec++; if (lat !== 4) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected 4", i, lat); end
        end
    endtask

    task automatic test_lanes_sweep();
        logic [63:0] v, exp, res_a, res_b; logic inv; int lat_a, lat_b;
        for (int k = 0; k < 5; k++) begin
            v   = (k == 0) ? 64'h0123456789ABCDEF : {$urandom, $urandom};
            inv = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            exp = ref_sub(v, inv);
            @(negedge clk);
            s_in_state = v; s_in_inv = inv; s_in_valid = 1'b1;
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            lat_a = -1; lat_b = -1; res_a = '0; res_b = '0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (a_out_valid && lat_a < 0) begin lat_a = c; res_a = a_out_state; end
                if (b_out_valid && lat_b < 0) begin lat_b = c; res_b = b_out_state; end
            end
            n_vec++; if (lat_a !== 16) begin n_err++; $display("FAIL l1_latency[%0d]: got %0d expected 16", k, lat_a); end
            n_vec++; if (lat_b !== 1) begin n_err++; $display("FAIL l16_latency[%0d]: got %0d expected 1", k, lat_b); end
            n_vec++; if (res_a !== exp) begin n_err++; $display("FAIL l1_state[%0d]: got %h expected %h", k, res_a, exp); end
            n_vec++; if (res_b !== exp) begin n_err++; $display("FAIL l16_state[%0d]: got %h expected %h", k, res_b, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_forward_vector();
        test_inverse();
        test_backpressure();
        test_reset_midop();
        test_random();
        test_lanes_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
